// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial add/sub sequencer around a shared 4-bit adder
// The adder is external and combinational; state, carry and operands are held here.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] A_in,
  input  logic [W-1:0] B_in,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S_out,
  output logic         Cout_out,
  output logic         V_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            sub_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    s_q;
  logic            cout_q;
  logic            v_q;
  logic            busy_q;
  logic            done_q;
  logic [IW+1:0]   base_d;
  logic            v_d;

  assign base_d = {idx_q, 2'b00};
  // Overflow uses the post-inversion B MSB, i.e. the value actually fed to the adder.
  assign v_d    = (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);

  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[base_d +: 4];
      add_b   = b_q[base_d +: 4] ^ {4{sub_q}};
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A_in;
            b_q     <= B_in;
            sub_q   <= sub;
            idx_q   <= '0;
            carry_q <= sub;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q[base_d +: 4] <= add_s;
          carry_q          <= add_cout;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            cout_q  <= add_cout;
            v_q     <= v_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign S_out    = s_q;
  assign Cout_out = cout_q;
  assign V_out    = v_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [15:0] S_out;
  logic        Cout_out;
  logic        V_out;
  logic [4:0]  sum5;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int done_cnt;

  always #5 clk = ~clk;

  assign sum5     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_s    = sum5[3:0];
  assign add_cout = sum5[4];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .A_in(A_in), .B_in(B_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .S_out(S_out),
    .Cout_out(Cout_out), .V_out(V_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the accepting edge, inputs scrambled.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    A_in  = a;
    B_in  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A_in  = 16'($urandom);
    B_in  = 16'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec, input logic ev);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) check({tag, "_early_done"}, {31'b0, done}, 32'd0);
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_S"}, {16'b0, S_out}, {16'b0, es});
    check({tag, "_Cout"}, {31'b0, Cout_out}, {31'b0, ec});
    check({tag, "_V"}, {31'b0, V_out}, {31'b0, ev});
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A_in  = 16'h0;
    B_in  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", {16'b0, S_out}, 32'd0);
    check("rst_flags", {28'b0, Cout_out, V_out, busy, done}, 32'd0);
    check("rst_adder", {23'b0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: plain add, latency checked inside finish_op
    start_op(16'h1234, 16'h4321, 1'b0);
    check("c1_busy", {31'b0, busy}, 32'd1);
    check("c1_first_a", {28'b0, add_a}, 32'h4);
    finish_op("c1", 16'h5555, 1'b0, 1'b0);

    // 2: carry ripples through every nibble
    start_op(16'hFFFF, 16'h0001, 1'b0);
    finish_op("c2", 16'h0000, 1'b1, 1'b0);

    // 3: subtraction with borrow
    start_op(16'h0005, 16'h0007, 1'b1);
    check("c3_first_a", {28'b0, add_a}, 32'h5);
    check("c3_first_b", {28'b0, add_b}, 32'h8);
    check("c3_first_cin", {31'b0, add_cin}, 32'd1);
    finish_op("c3", 16'hFFFE, 1'b0, 1'b0);

    // 4: signed overflow both directions
    start_op(16'h7FFF, 16'h0001, 1'b0);
    finish_op("c4a", 16'h8000, 1'b0, 1'b1);
    start_op(16'h8000, 16'h0001, 1'b1);
    finish_op("c4b", 16'h7FFF, 1'b1, 1'b1);

    // 5: start while busy is ignored
    start_op(16'h1234, 16'h4321, 1'b0);
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin
        start = 1'b1;
        A_in  = 16'h1111;
        B_in  = 16'h1111;
        sub   = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("c5_S", {16'b0, S_out}, 32'h5555);
    check("c5_busy_cycles", busy_cnt, 32'd5);
    check("c5_done_pulses", done_cnt, 32'd1);

    // 6: async reset in the 2nd RUN cycle aborts the operation
    start_op(16'h2222, 16'h3333, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("c6_rst_S", {16'b0, S_out}, 32'd0);
    check("c6_rst_flags", {30'b0, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("c6_no_done", done_cnt, 32'd0);
    start_op(16'h2222, 16'h3333, 1'b0);
    finish_op("c6_after", 16'h5555, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
